// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } scrub_state_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: address decode over the flattened storage,
// hardwired-zero masking of entry 0 and same-cycle write forwarding.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic [(2**ADDR_W)*DATA_W-1:0] entries,
    input  logic [ADDR_W-1:0]             address,
    input  logic                          wr_accept,
    input  logic [ADDR_W-1:0]             wr_address,
    input  logic [DATA_W-1:0]             wr_data,
    output logic [DATA_W-1:0]             data
);

    localparam int DEPTH     = 2**ADDR_W;
    localparam bit ZERO_EN   = (ZERO_REG != 0);
    localparam bit BYPASS_EN = (BYPASS != 0);

    logic [DATA_W-1:0] stored;
    logic              hit;
    logic              is_zero;

    // Decode the stored value, then apply zero-entry mask ahead of the bypass.
    always_comb begin
        stored = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (address == ADDR_W'(i)) begin
                stored = entries[i*DATA_W +: DATA_W];
            end
        end
        hit     = BYPASS_EN && wr_accept && (wr_address == address);
        is_zero = ZERO_EN && (address == '0);
        if (is_zero) begin
            data = '0;
        end else if (hit) begin
            data = wr_data;
        end else begin
            data = stored;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-read-port register file with a sequential scrub engine.
//
// Scrub FSM:
//   state | meaning
//   IDLE  | no scrub; writes accepted; clear_req starts a scrub at entry 0
//   CLEAR | busy; one entry zeroed per cycle, pointer counts up to DEPTH-1
//   DONE  | clear_done high for one cycle; returns to IDLE unconditionally
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     write,
    output logic                     write_ready,
    input  logic [ADDR_W-1:0]        write_address,
    input  logic [DATA_W-1:0]        write_data,
    input  logic [NUM_RD*ADDR_W-1:0] read_address,
    output logic [NUM_RD*DATA_W-1:0] read_data,
    input  logic                     clear_req,
    output logic                     busy,
    output logic                     clear_done
);

    localparam int              DEPTH    = 2**ADDR_W;
    localparam bit              ZERO_EN  = (ZERO_REG != 0);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0]       mem [DEPTH] = '{default: '0};
    logic [DEPTH*DATA_W-1:0] mem_flat;

    scrub_state_t      state;
    logic [ADDR_W-1:0] ptr;
    logic              busy_q;
    logic              done_q;

    logic wr_accept;
    logic wr_store;

    // Writes are refused while scrubbing; entry 0 writes are dropped when hardwired.
    always_comb begin
        wr_accept = write && !busy_q;
        wr_store  = wr_accept && !(ZERO_EN && (write_address == '0));
    end

    assign write_ready = !busy_q;
    assign busy        = busy_q;
    assign clear_done  = done_q;

    // Storage update: reset clears everything at once, scrub clears one entry per cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == CLEAR) begin
            mem[ptr] <= '0;
        end else if (wr_store) begin
            mem[write_address] <= write_data;
        end
    end

    // Scrub sequencer with registered busy and clear_done.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= IDLE;
            ptr    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (clear_req) begin
                        state  <= CLEAR;
                        ptr    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (ptr == LAST_PTR) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    // Flatten the array so each read port sees the whole storage as one vector.
    always_comb begin
        mem_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_flat[i*DATA_W +: DATA_W] = mem[i];
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .entries    (mem_flat),
            .address    (read_address[k*ADDR_W +: ADDR_W]),
            .wr_accept  (wr_accept),
            .wr_address (write_address),
            .wr_data    (write_data),
            .data       (read_data[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp across three configurations:
//   a: 16-bit x 8, 2 ports, bypass, no zero entry
//   b: 16-bit x 8, 2 ports, no bypass, hardwired zero entry
//   c: 32-bit x 32, 3 ports, bypass
module tb_register_file_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic        a_reset, a_write, a_wready, a_clr, a_busy, a_done;
    logic [2:0]  a_waddr;
    logic [15:0] a_wdata;
    logic [5:0]  a_raddr;
    logic [31:0] a_rdata;

    logic        b_reset, b_write, b_wready, b_clr, b_busy, b_done;
    logic [2:0]  b_waddr;
    logic [15:0] b_wdata;
    logic [5:0]  b_raddr;
    logic [31:0] b_rdata;

    logic        c_reset, c_write, c_wready, c_clr, c_busy, c_done;
    logic [4:0]  c_waddr;
    logic [31:0] c_wdata;
    logic [14:0] c_raddr;
    logic [95:0] c_rdata;

    register_file_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(0), .BYPASS(1)) dut_a (
        .clock(clk), .reset(a_reset), .write(a_write), .write_ready(a_wready),
        .write_address(a_waddr), .write_data(a_wdata), .read_address(a_raddr),
        .read_data(a_rdata), .clear_req(a_clr), .busy(a_busy), .clear_done(a_done)
    );

    register_file_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clock(clk), .reset(b_reset), .write(b_write), .write_ready(b_wready),
        .write_address(b_waddr), .write_data(b_wdata), .read_address(b_raddr),
        .read_data(b_rdata), .clear_req(b_clr), .busy(b_busy), .clear_done(b_done)
    );

    register_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3), .ZERO_REG(0), .BYPASS(1)) dut_c (
        .clock(clk), .reset(c_reset), .write(c_write), .write_ready(c_wready),
        .write_address(c_waddr), .write_data(c_wdata), .read_address(c_raddr),
        .read_data(c_rdata), .clear_req(c_clr), .busy(c_busy), .clear_done(c_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_put(input logic [2:0] ad, input logic [15:0] d);
        a_write = 1'b1; a_waddr = ad; a_wdata = d;
        tick();
        a_write = 1'b0;
    endtask

    task automatic b_put(input logic [2:0] ad, input logic [15:0] d);
        b_write = 1'b1; b_waddr = ad; b_wdata = d;
        tick();
        b_write = 1'b0;
    endtask

    task automatic c_put(input logic [4:0] ad, input logic [31:0] d);
        c_write = 1'b1; c_waddr = ad; c_wdata = d;
        tick();
        c_write = 1'b0;
    endtask

    task automatic a_fill(input logic [15:0] d);
        for (int i = 0; i < 8; i++) a_put(3'(i), d);
    endtask

    task automatic test_reset();
        a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
        repeat (2) tick();
        a_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;
        tests_run++; if (a_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", a_busy); end
        tests_run++; if (a_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b exp 0", a_done); end
        tests_run++; if (a_wready !== 1'b1) begin tests_failed++; $display("FAIL reset_wready got %b exp 1", a_wready); end
        tests_run++; if (c_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_c_busy got %b exp 0", c_busy); end
        a_fill(16'hABCD);
        a_raddr = {3'd7, 3'd0}; #1;
        tests_run++; if (a_rdata[15:0] !== 16'hABCD) begin tests_failed++; $display("FAIL prefill got %h exp abcd", a_rdata[15:0]); end
        a_reset = 1'b0; a_write = 1'b1; a_waddr = 3'd3; a_wdata = 16'h1111;
        tick();
        a_reset = 1'b1; a_write = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a_raddr = {3'(7 - i), 3'(i)}; #1;
            tests_run++; if (a_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_clear entry %0d got %h exp 0", i, a_rdata); end
        end
        tests_run++; if (a_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy_after got %b exp 0", a_busy); end
    endtask

    task automatic test_write_readback();
        a_put(3'd5, 16'h7777);
        b_put(3'd5, 16'h7777);
        a_write = 1'b1; a_waddr = 3'd5; a_wdata = 16'h1234; a_raddr = {3'd5, 3'd5};
        b_write = 1'b1; b_waddr = 3'd5; b_wdata = 16'h1234; b_raddr = {3'd5, 3'd5};
        #1;
        tests_run++; if (a_rdata[31:16] !== 16'h1234) begin tests_failed++; $display("FAIL bypass_on got %h exp 1234", a_rdata[31:16]); end
        tests_run++; if (b_rdata[31:16] !== 16'h7777) begin tests_failed++; $display("FAIL bypass_off got %h exp 7777", b_rdata[31:16]); end
        tick();
        a_write = 1'b0; b_write = 1'b0; #1;
        tests_run++; if (a_rdata[15:0] !== 16'h1234) begin tests_failed++; $display("FAIL readback_a got %h exp 1234", a_rdata[15:0]); end
        tests_run++; if (b_rdata !== {16'h1234, 16'h1234}) begin tests_failed++; $display("FAIL readback_b got %h exp 12341234", b_rdata); end
    endtask

    task automatic test_zero_reg();
        b_put(3'd1, 16'h2222);
        b_write = 1'b1; b_waddr = 3'd0; b_wdata = 16'hFFFF; b_raddr = {3'd0, 3'd0};
        a_write = 1'b1; a_waddr = 3'd0; a_wdata = 16'hFFFF; a_raddr = {3'd0, 3'd0};
        #1;
        tests_run++; if (b_rdata !== 32'h0) begin tests_failed++; $display("FAIL zero_same_cycle got %h exp 0", b_rdata); end
        tests_run++; if (b_wready !== 1'b1) begin tests_failed++; $display("FAIL zero_wready got %b exp 1", b_wready); end
        tests_run++; if (a_rdata[31:16] !== 16'hFFFF) begin tests_failed++; $display("FAIL nonzero_bypass0 got %h exp ffff", a_rdata[31:16]); end
        tick();
        a_write = 1'b0; b_write = 1'b0; #1;
        tests_run++; if (b_rdata !== 32'h0) begin tests_failed++; $display("FAIL zero_next_cycle got %h exp 0", b_rdata); end
        tests_run++; if (a_rdata[15:0] !== 16'hFFFF) begin tests_failed++; $display("FAIL nonzero_entry0 got %h exp ffff", a_rdata[15:0]); end
        b_raddr = {3'd1, 3'd0}; #1;
        tests_run++; if (b_rdata[31:16] !== 16'h2222) begin tests_failed++; $display("FAIL zero_neighbour got %h exp 2222", b_rdata[31:16]); end
    endtask

    task automatic test_back_to_back();
        int n;
        for (int i = 1; i <= 3; i++) begin
            a_write = 1'b1; a_waddr = 3'(i); a_wdata = 16'h1000 + 16'(i);
            a_raddr = {3'(i), 3'(i)}; #1;
            tests_run++; if (a_rdata[31:16] !== 16'h1000 + 16'(i)) begin tests_failed++; $display("FAIL b2b_bypass %0d got %h", i, a_rdata[31:16]); end
            tick();
        end
        a_write = 1'b0;
        a_raddr = {3'd3, 3'd1}; #1;
        tests_run++; if (a_rdata !== {16'h1003, 16'h1001}) begin tests_failed++; $display("FAIL b2b_readback got %h exp 10031001", a_rdata); end
        a_clr = 1'b1; a_write = 1'b1; a_waddr = 3'd6; a_wdata = 16'h6666;
        tick();
        a_clr = 1'b0; a_write = 1'b0; a_raddr = {3'd6, 3'd6}; #1;
        tests_run++; if (a_busy !== 1'b1) begin tests_failed++; $display("FAIL clr_write_busy got %b exp 1", a_busy); end
        tests_run++; if (a_rdata[15:0] !== 16'h6666) begin tests_failed++; $display("FAIL clr_write_kept got %h exp 6666", a_rdata[15:0]); end
        n = 0;
        while (a_done !== 1'b1 && n < 20) begin tick(); n++; end
        tests_run++; if (a_done !== 1'b1) begin tests_failed++; $display("FAIL clr_write_done got %b exp 1 (timeout)", a_done); end
        tick();
        tests_run++; if (a_rdata[15:0] !== 16'h0000) begin tests_failed++; $display("FAIL clr_write_scrubbed got %h exp 0", a_rdata[15:0]); end
    endtask

    task automatic test_scrub();
        int busy_cnt, done_cnt;
        a_fill(16'h00FF);
        a_clr = 1'b1; tick(); a_clr = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (cyc == 1) begin
                tests_run++; if (a_busy !== 1'b1) begin tests_failed++; $display("FAIL scrub_busy_rise got %b exp 1", a_busy); end
            end
            if (a_busy === 1'b1) busy_cnt++;
            if (a_done === 1'b1) done_cnt++;
            if (cyc == 3) begin
                a_raddr = {3'd7, 3'd0}; #1;
                tests_run++; if (a_rdata !== {16'h00FF, 16'h0000}) begin tests_failed++; $display("FAIL scrub_partial got %h exp 00ff0000", a_rdata); end
            end
            if (cyc == 4) a_clr = 1'b1;
            if (cyc == 5) begin
                a_write = 1'b1; a_waddr = 3'd7; a_wdata = 16'h5555; a_raddr = {3'd7, 3'd7}; #1;
                tests_run++; if (a_wready !== 1'b0) begin tests_failed++; $display("FAIL scrub_wready got %b exp 0", a_wready); end
                tests_run++; if (a_rdata[31:16] !== 16'h00FF) begin tests_failed++; $display("FAIL scrub_no_fwd got %h exp 00ff", a_rdata[31:16]); end
            end
            if (cyc == 6) begin
                tests_run++; if (a_rdata[15:0] !== 16'h00FF) begin tests_failed++; $display("FAIL scrub_write_lost got %h exp 00ff", a_rdata[15:0]); end
            end
            if (cyc == 9) begin
                tests_run++; if ({a_done, a_busy} !== 2'b10) begin tests_failed++; $display("FAIL scrub_done_cycle got %b exp 10", {a_done, a_busy}); end
                a_clr = 1'b1;
            end
            tick();
            a_clr = 1'b0; a_write = 1'b0;
        end
        tests_run++; if (busy_cnt != 8) begin tests_failed++; $display("FAIL scrub_busy_len got %0d exp 8", busy_cnt); end
        tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL scrub_done_cnt got %0d exp 1", done_cnt); end
        for (int i = 0; i < 8; i++) begin
            a_raddr = {3'(i), 3'(7 - i)}; #1;
            tests_run++; if (a_rdata !== 32'h0) begin tests_failed++; $display("FAIL scrub_result entry %0d got %h exp 0", i, a_rdata); end
        end
    endtask

    task automatic test_reset_mid_scrub();
        int busy_cnt, done_cnt;
        a_fill(16'h00FF);
        a_clr = 1'b1; tick(); a_clr = 1'b0;
        repeat (3) tick();
        tests_run++; if (a_busy !== 1'b1) begin tests_failed++; $display("FAIL mid_busy got %b exp 1", a_busy); end
        a_reset = 1'b0; tick(); a_reset = 1'b1;
        done_cnt = 0;
        tests_run++; if (a_busy !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_busy got %b exp 0", a_busy); end
        for (int i = 0; i < 8; i++) begin
            a_raddr = {3'(i), 3'(i)}; #1;
            tests_run++; if (a_rdata !== 32'h0) begin tests_failed++; $display("FAIL mid_reset_entry %0d got %h exp 0", i, a_rdata); end
        end
        for (int i = 0; i < 4; i++) begin
            if (a_done === 1'b1) done_cnt++;
            tick();
        end
        tests_run++; if (done_cnt != 0) begin tests_failed++; $display("FAIL mid_reset_done got %0d exp 0", done_cnt); end
        a_clr = 1'b1; tick(); a_clr = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (a_busy === 1'b1) busy_cnt++;
            if (a_done === 1'b1) done_cnt++;
            tick();
        end
        tests_run++; if (busy_cnt != 8 || done_cnt != 1) begin tests_failed++; $display("FAIL rescrub got busy %0d done %0d exp 8 1", busy_cnt, done_cnt); end
    endtask

    task automatic test_generality();
        int busy_cnt, done_cnt;
        c_put(5'd31, 32'hDEADBEEF);
        c_put(5'd0, 32'h01234567);
        c_put(5'd17, 32'hCAFEF00D);
        c_raddr = {5'd17, 5'd0, 5'd31}; #1;
        tests_run++; if (c_rdata !== {32'hCAFEF00D, 32'h01234567, 32'hDEADBEEF}) begin tests_failed++; $display("FAIL wide_read1 got %h", c_rdata); end
        c_raddr = {5'd31, 5'd17, 5'd0}; #1;
        tests_run++; if (c_rdata !== {32'hDEADBEEF, 32'hCAFEF00D, 32'h01234567}) begin tests_failed++; $display("FAIL wide_read2 got %h", c_rdata); end
        c_clr = 1'b1; tick(); c_clr = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            if (c_busy === 1'b1) busy_cnt++;
            if (c_done === 1'b1) done_cnt++;
            tick();
        end
        tests_run++; if (busy_cnt != 32) begin tests_failed++; $display("FAIL wide_busy_len got %0d exp 32", busy_cnt); end
        tests_run++; if (done_cnt != 1) begin tests_failed++; $display("FAIL wide_done_cnt got %0d exp 1", done_cnt); end
        #1;
        tests_run++; if (c_rdata !== 96'h0) begin tests_failed++; $display("FAIL wide_scrubbed got %h exp 0", c_rdata); end
    endtask

    initial begin
        a_reset = 1'b0; a_write = 1'b0; a_clr = 1'b0; a_waddr = '0; a_wdata = '0; a_raddr = '0;
        b_reset = 1'b0; b_write = 1'b0; b_clr = 1'b0; b_waddr = '0; b_wdata = '0; b_raddr = '0;
        c_reset = 1'b0; c_write = 1'b0; c_clr = 1'b0; c_waddr = '0; c_wdata = '0; c_raddr = '0;
        test_reset();
        test_write_readback();
        test_zero_reg();
        test_back_to_back();
        test_scrub();
        test_reset_mid_scrub();
        test_generality();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-read-port register file; next generation of the architecture's 16-bit, 8-entry general-purpose register file.
- Adds configurable width, depth and read-port count.
- Adds optional hardwired-zero entry 0 and optional write-to-read bypass.
- Adds a sequential scrub (clear) engine with a busy/ready handshake.
- Sits between decode (read addresses) and writeback (write port) in the datapath.

Parameters:
- DATA_W, 16: entry width in bits.
- ADDR_W, 3: address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2: number of independent combinational read ports.
- ZERO_REG, 0: 1 = entry 0 always reads 0 and writes to it are discarded.
- BYPASS, 1: 1 = an accepted same-cycle write is forwarded to matching read ports.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- write  in  1  write request.
- write_ready  out  1  = !busy; a write is accepted only when write & write_ready.
- write_address  in  ADDR_W  target entry.
- write_data  in  DATA_W  data to store.
- read_address  in  NUM_RD*ADDR_W  port k address in bits [k*ADDR_W +: ADDR_W].
- read_data  out  NUM_RD*DATA_W  port k data in bits [k*DATA_W +: DATA_W].
- clear_req  in  1  single-cycle pulse that starts a scrub of all entries.
- busy  out  1  high while a scrub is in progress.
- clear_done  out  1  one-cycle pulse when a scrub completes.

Behaviour:
- Reset (reset==0 at a clock edge):
  - all DEPTH entries become 0 in that single cycle.
  - FSM goes to IDLE, scrub pointer goes to 0.
  - busy=0, clear_done=0.
  - Reset overrides any in-progress scrub and any same-cycle write.
  - Contents also initialise to 0 at time zero.
- Read ports:
  - combinational, zero latency; read_data[k] = entry[read_address[k]].
  - ZERO_REG=1 and address 0: read_data[k]=0 regardless of bypass.
  - BYPASS=1, accepted write this cycle, write_address==read_address[k] (and not the zeroed entry): read_data[k]=write_data.
  - BYPASS=0: a read returns the pre-write value until the next cycle.
- Write:
  - accepted write updates entry[write_address] at the clock edge; the new value is visible on the next cycle.
  - ZERO_REG=1 and write_address==0: the write is accepted but discarded.
  - write while busy: not accepted, no state change, and not forwarded.
- Scrub FSM states:
  - IDLE: busy=0. clear_req=1 -> CLEAR with pointer=0; busy rises the next cycle.
  - CLEAR: busy=1. Each cycle entry[pointer] <- 0 and pointer increments. When pointer==DEPTH-1, the clear completes -> DONE.
  - DONE: busy=0, clear_done=1 for exactly one cycle, then -> IDLE unconditionally. A clear_req in DONE is ignored.
- Scrub timing and interactions:
  - busy is high for exactly DEPTH cycles.
  - clear_req while in CLEAR is ignored (no restart).
  - clear_req and write in the same IDLE cycle: the write is accepted; the scrub starts next cycle and will zero that entry.
  - Reads during CLEAR return current contents: already-cleared entries read 0, the rest read old values.
- Pointer arithmetic: pointer is ADDR_W bits; the DEPTH-1 compare terminates the scrub, so no wrap past DEPTH-1 ever occurs.
- NUM_RD >= 1; DEPTH >= 2.

Decomposition:
- Package regfile_pkg:
  - typedef enum for scrub state {IDLE, CLEAR, DONE}.
  - default localparams DATA_W_DEF=16, ADDR_W_DEF=3.
- Sub-module regfile_read_port (one per port via generate): address decode, zero-reg masking and bypass compare/mux.
- Storage array, write logic and scrub FSM stay in the top module.

Test Plan:
- Reset with 8 entries: write 16'hABCD to entries 0..7, assert reset low for 1 cycle -> all 8 entries read 0 on both ports; busy=0.
- Write/readback: write 16'h1234 to address 5; next cycle read_address0=5 -> 16'h1234. Same cycle, port1 at 5 reads 16'h1234 when BYPASS=1 and the old value when BYPASS=0.
- Zero reg: ZERO_REG=1, write 16'hFFFF to address 0 -> both ports read 0 at address 0, both in the same cycle and the next; address 1 is unaffected.
- Scrub: fill entries with 16'h00FF, pulse clear_req.
  - busy is high for exactly 8 cycles; a write of 16'h5555 during busy has write_ready=0 and is lost.
  - clear_done pulses once; all entries then read 0.
  - Sampling entry 7 at busy cycle 3 returns 16'h00FF.
- Reset mid-scrub: assert reset at busy cycle 4 -> next cycle busy=0, no clear_done, all entries 0; a new clear_req runs a full 8-cycle scrub.
- Generality: DATA_W=32, ADDR_W=5, NUM_RD=3.
  - simultaneous reads of 3 different addresses after writes to 31, 0 and 17 return the correct 32-bit values.
  - scrub busy lasts 32 cycles.
